pipeline_sequencer: RTL and testbench

- Central hazard and sequencing controller for the pipelined rv32i core.
- Drives the load and flush controls of the PC register and the four pipeline registers: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Arbitrates the single-ported unified memory between instruction fetch and MEM-stage data access, including multi-cycle waits.
- Resolves load-use and branch hazards, and keeps stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_detect.sv | 18 +
 rtl/pipeline_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the rv32i pipeline sequencer
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_e;

   localparam logic MEM_SEL_FETCH = 1'b0;
   localparam logic MEM_SEL_DATA  = 1'b1;

   localparam int RF_AW_DEF = 5;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between EX load and ID sources
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int RF_AW = RF_AW_DEF
) (
   input  logic [RF_AW-1:0] id_rs1,
   input  logic [RF_AW-1:0] id_rs2,
   input  logic [RF_AW-1:0] ex_rd,
   input  logic             ex_mem_read,
   output logic             lu_stall
);

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign lu_stall = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - hazard, memory-arbitration and flush/stall control
module pipeline_sequencer
   import pipe_pkg::*;
#(
   parameter int RF_AW    = RF_AW_DEF,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RF_AW-1:0] id_rs1,
   input  logic [RF_AW-1:0] id_rs2,
   input  logic [RF_AW-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_load,
   output logic             ifid_load,
   output logic             idex_load,
   output logic             exmem_load,
   output logic             memwb_load,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             mem_sel,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              lu_stall;
   logic              use_run;
   logic              eff_req;
   logic              eff_ready;
   logic              active;
   logic              flush_evt;
   logic [WAIT_W-1:0] wait_inc;

   hazard_detect #(
      .RF_AW(RF_AW)
   ) u_hazard (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .ex_rd      (ex_rd),
      .ex_mem_read(ex_mem_read),
      .lu_stall   (lu_stall)
   );

   assign wait_inc = wait_q + WAIT_W'(1);

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      pc_load    = 1'b1;
      ifid_load  = 1'b1;
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      mem_sel    = MEM_SEL_FETCH;
      use_run    = 1'b0;
      eff_req    = 1'b0;
      eff_ready  = 1'b0;
      active     = 1'b0;
      flush_evt  = 1'b0;

      case (state_q)
         RUN: begin
            active    = 1'b1;
            use_run   = 1'b1;
            eff_req   = mem_req;
            eff_ready = mem_ready;
         end
         MEM_WAIT: begin
            active = 1'b1;
            if (mem_ready) begin
               // Release cycle behaves like a single-cycle data access in RUN
               use_run   = 1'b1;
               eff_req   = 1'b1;
               eff_ready = 1'b1;
               state_d   = RUN;
               wait_d    = '0;
            end else begin
               {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
               mem_sel = MEM_SEL_DATA;
               wait_d  = wait_inc;
               if (wait_inc == WAIT_W'(MAX_WAIT)) begin
                  state_d = ERR;
               end
            end
         end
         default: begin
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
         end
      endcase

      if (use_run) begin
         if (eff_req && !eff_ready) begin
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
            mem_sel = MEM_SEL_DATA;
            state_d = MEM_WAIT;
            wait_d  = WAIT_W'(1);
         end else begin
            mem_sel = eff_req ? MEM_SEL_DATA : MEM_SEL_FETCH;
            if (ex_branch_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               flush_evt  = 1'b1;
            end else if (lu_stall) begin
               // IF/ID holds the dependent instruction; a bubble goes into EX
               pc_load    = 1'b0;
               ifid_load  = 1'b0;
               idex_flush = 1'b1;
            end else if (eff_req) begin
               pc_load    = 1'b0;
               ifid_flush = 1'b1;
            end
         end
      end

      if (rst) begin
         {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         mem_sel    = MEM_SEL_FETCH;
         state_d    = RUN;
         wait_d     = '0;
         active     = 1'b0;
         flush_evt  = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (active && !pc_load && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (flush_evt && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wait_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign err       = !rst && (state_q == ERR);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed vector bench for pipeline_sequencer
module tb_pipeline_sequencer;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       ex_mem_read, ex_branch_taken, mem_req, mem_ready;
   logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
   logic       ifid_flush, idex_flush, mem_sel, err;
   logic [31:0] stall_cnt, flush_cnt;
   logic       s_pc_load, s_ifid_load, s_idex_load, s_exmem_load, s_memwb_load;
   logic       s_ifid_flush, s_idex_flush, s_mem_sel, s_err;
   logic [3:0] s_stall_cnt, s_flush_cnt;

   int vectors;
   int miscompares;
   int exp_stall;
   int exp_flush;

   pipeline_sequencer #(.RF_AW(5), .MAX_WAIT(15), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
      .exmem_load(exmem_load), .memwb_load(memwb_load),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mem_sel(mem_sel),
      .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_sequencer #(.RF_AW(5), .MAX_WAIT(15), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_load(s_pc_load), .ifid_load(s_ifid_load), .idex_load(s_idex_load),
      .exmem_load(s_exmem_load), .memwb_load(s_memwb_load),
      .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .mem_sel(s_mem_sel),
      .err(s_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, mem_sel}
   localparam logic [7:0] O_RUN    = 8'b11111_00_0;
   localparam logic [7:0] O_RESET  = 8'b00000_11_0;
   localparam logic [7:0] O_FREEZE = 8'b00000_00_1;
   localparam logic [7:0] O_ERR    = 8'b00000_00_0;
   localparam logic [7:0] O_REL    = 8'b01111_10_1;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       mrd, br, req, rdy;
      logic [7:0] exp;
   } vec_t;

   vec_t vt[9];

   function automatic logic [7:0] outs();
      return {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
              ifid_flush, idex_flush, mem_sel};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      clr();
      tick();
      rst = 0;
      exp_stall = 0;
      exp_flush = 0;
   endtask

   initial begin
      vectors = 0; miscompares = 0; exp_stall = 0; exp_flush = 0;
      vt[0] = '{5'd1, 5'd2, 5'd3, 1, 0, 0, 0, O_RUN};
      vt[1] = '{5'd4, 5'd5, 5'd5, 1, 0, 0, 0, 8'b00111_01_0};
      vt[2] = '{5'd0, 5'd0, 5'd0, 1, 0, 0, 0, O_RUN};
      vt[3] = '{5'd7, 5'd2, 5'd7, 0, 0, 0, 0, O_RUN};
      vt[4] = '{5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 8'b11111_11_0};
      vt[5] = '{5'd1, 5'd2, 5'd3, 0, 0, 1, 1, 8'b01111_10_1};
      vt[6] = '{5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 8'b11111_11_1};
      vt[7] = '{5'd9, 5'd3, 5'd9, 1, 0, 1, 1, 8'b00111_01_1};
      vt[8] = '{5'd31, 5'd0, 5'd31, 1, 0, 0, 0, 8'b00111_01_0};

      rst = 1;
      clr();
      #2;
      chk("reset_outs", 32'(outs()), 32'(O_RESET));
      chk("reset_err", 32'(err), 32'd0);
      tick();
      chk("reset_stall_cnt", stall_cnt, 32'd0);
      chk("reset_flush_cnt", flush_cnt, 32'd0);
      chk("reset_outs2", 32'(outs()), 32'(O_RESET));
      tick();
      rst = 0;
      #2;
      chk("idle_run", 32'(outs()), 32'(O_RUN));

      for (int i = 0; i < 9; i++) begin
         id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; ex_rd = vt[i].rd;
         ex_mem_read = vt[i].mrd; ex_branch_taken = vt[i].br;
         mem_req = vt[i].req; mem_ready = vt[i].rdy;
         #2;
         chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].exp));
         if (!vt[i].exp[7]) exp_stall++;
         if (vt[i].br) exp_flush++;
         tick();
         chk($sformatf("vec%0d_stall", i), stall_cnt, 32'(exp_stall));
         chk($sformatf("vec%0d_flush", i), flush_cnt, 32'(exp_flush));
      end

      // multi-cycle access: 3 frozen cycles then release
      clr();
      mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk($sformatf("wait%0d_outs", i), 32'(outs()), 32'(O_FREEZE));
         exp_stall++;
         tick();
      end
      mem_ready = 1;
      #2;
      chk("release_outs", 32'(outs()), 32'(O_REL));
      exp_stall++;
      tick();
      clr();
      #2;
      chk("after_release", 32'(outs()), 32'(O_RUN));
      chk("release_stall", stall_cnt, 32'(exp_stall));
      tick();

      // timeout into ERR
      mem_req = 1;
      for (int i = 0; i < 15; i++) begin
         #2;
         chk($sformatf("to%0d_outs", i), 32'(outs()), 32'(O_FREEZE));
         chk($sformatf("to%0d_err", i), 32'(err), 32'd0);
         exp_stall++;
         tick();
      end
      #2;
      chk("err_set", 32'(err), 32'd1);
      chk("err_outs", 32'(outs()), 32'(O_ERR));
      chk("err_stall", stall_cnt, 32'(exp_stall));
      mem_ready = 1;
      tick();
      #2;
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_outs_hold", 32'(outs()), 32'(O_ERR));
      tick();
      chk("err_no_count", stall_cnt, 32'(exp_stall));
      do_reset();
      #2;
      chk("err_cleared", 32'(err), 32'd0);
      chk("err_reset_run", 32'(outs()), 32'(O_RUN));
      chk("err_reset_stall", stall_cnt, 32'd0);

      // reset in the middle of a wait
      mem_req = 1;
      for (int i = 0; i < 7; i++) tick();
      rst = 1;
      #2;
      chk("midwait_rst_outs", 32'(outs()), 32'(O_RESET));
      tick();
      rst = 0;
      clr();
      #2;
      chk("midwait_run", 32'(outs()), 32'(O_RUN));
      chk("midwait_err", 32'(err), 32'd0);
      mem_req = 1;
      for (int i = 0; i < 14; i++) tick();
      #2;
      chk("midwait_counter_cleared", 32'(err), 32'd0);
      chk("midwait_still_frozen", 32'(outs()), 32'(O_FREEZE));
      mem_ready = 1;
      tick();
      do_reset();

      // saturation on the 4-bit counter instance
      ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall", 32'(s_stall_cnt), 32'd15);
      chk("wide_stall", stall_cnt, 32'd20);
      tick();
      tick();
      chk("sat_hold", 32'(s_stall_cnt), 32'd15);
      chk("sat_flush", 32'(s_flush_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
